// File: rtl/mem_bus_master.sv
// External memory bus master: runs one read or write cycle with wait states for the 6502 core.
// Optional macro MEMBUS_TIMEOUT_EN aborts a STROBE phase after TIMEOUT_CYCLES wait states (ERR=1).
module mem_bus_master #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ,
    input  logic        WE,
    input  logic [7:0]  ADL_DATA,
    input  logic [7:0]  ADH_DATA,
    input  logic [7:0]  DB_DATA,
    output logic        BUSY,
    output logic        ACK,
    output logic        ERR,
    output logic [7:0]  RD_DATA,
    output logic [15:0] A,
    output logic        RW,
    output logic        STB,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    input  logic        MEM_RDY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  rdata_q, rdata_d;

`ifdef MEMBUS_TIMEOUT_EN
    // The abort fires on the edge where the wait count would reach TIMEOUT_CYCLES.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
`ifdef MEMBUS_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    addr_d = {ADH_DATA, ADL_DATA};
                    rw_d   = ~WE;
                    if (WE) begin
                        dout_d = DB_DATA;
                    end
`ifdef MEMBUS_TIMEOUT_EN
                    err_d = 1'b0;
`endif
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
`ifdef MEMBUS_TIMEOUT_EN
                wait_cnt_d = 8'h00;
`endif
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (MEM_RDY) begin
                    if (rw_q) begin
                        rdata_d = D_IN;
                    end
                    state_d = S_DONE;
                end else begin
`ifdef MEMBUS_TIMEOUT_EN
                    wait_cnt_d = wait_cnt_q + 8'h01;
                    if (wait_cnt_q == WAIT_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            addr_q  <= 16'h0000;
            rw_q    <= 1'b1;
            dout_q  <= 8'h00;
            rdata_q <= 8'h00;
`ifdef MEMBUS_TIMEOUT_EN
            wait_cnt_q <= 8'h00;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
`ifdef MEMBUS_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign BUSY    = (state_q != S_IDLE);
    assign ACK     = (state_q == S_DONE);
    assign STB     = (state_q == S_STROBE);
    // Data driver only on writes, and only while the address phase is live.
    assign D_OE    = ~rw_q && ((state_q == S_SETUP) || (state_q == S_STROBE));
    assign A       = addr_q;
    assign RW      = rw_q;
    assign D_OUT   = dout_q;
    assign RD_DATA = rdata_q;

`ifdef MEMBUS_TIMEOUT_EN
    assign ERR = ACK && err_q;
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Scoreboard bench for mem_bus_master; the timeout scenario follows MEMBUS_TIMEOUT_EN.
module tb_mem_bus_master;

`ifdef MEMBUS_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 15;
`endif

    logic        CLK;
    logic        RST;
    logic        REQ;
    logic        WE;
    logic [7:0]  ADL_DATA;
    logic [7:0]  ADH_DATA;
    logic [7:0]  DB_DATA;
    logic        BUSY;
    logic        ACK;
    logic        ERR;
    logic [7:0]  RD_DATA;
    logic [15:0] A;
    logic        RW;
    logic        STB;
    logic [7:0]  D_OUT;
    logic        D_OE;
    logic [7:0]  D_IN;
    logic        MEM_RDY;

    mem_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
        .ADL_DATA(ADL_DATA), .ADH_DATA(ADH_DATA), .DB_DATA(DB_DATA),
        .BUSY(BUSY), .ACK(ACK), .ERR(ERR), .RD_DATA(RD_DATA),
        .A(A), .RW(RW), .STB(STB), .D_OUT(D_OUT), .D_OE(D_OE),
        .D_IN(D_IN), .MEM_RDY(MEM_RDY)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        rw;
        logic        err;
        logic [7:0]  rd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   acks  = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input logic rw, input logic err, input logic [7:0] rd);
        exp_t e;
        e.addr = a;
        e.rw   = rw;
        e.err  = err;
        e.rd   = rd;
        exp_q.push_back(e);
    endtask

    // Monitor: every ACK pops one expected completion.
    always @(negedge CLK) begin
        if (ACK === 1'b1) begin
            acks++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ACK at A=%0h required no ACK", A);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_addr", 32'(A), 32'(e.addr));
                chk("ack_rw", 32'(RW), 32'(e.rw));
                chk("ack_err", 32'(ERR), 32'(e.err));
                chk("ack_rd_data", 32'(RD_DATA), 32'(e.rd));
                $display("txn done: A=%04h RW=%0d ERR=%0d RD_DATA=%02h", A, RW, ERR, RD_DATA);
            end
        end
    end

    initial begin
        int busy_cycles;
        // Reset with garbage on the inputs
        RST = 1'b1; REQ = 1'b1; WE = 1'b1; ADL_DATA = 8'hC3; ADH_DATA = 8'h3C;
        DB_DATA = 8'hDE; D_IN = 8'hAD; MEM_RDY = 1'b0;
        step(); step();
        chk("rst_a", 32'(A), 32'h0000);
        chk("rst_rw", 32'(RW), 32'h1);
        chk("rst_stb", 32'(STB), 32'h0);
        chk("rst_dout", 32'(D_OUT), 32'h00);
        chk("rst_doe", 32'(D_OE), 32'h0);
        chk("rst_rd_data", 32'(RD_DATA), 32'h00);
        chk("rst_ack", 32'(ACK), 32'h0);
        chk("rst_err", 32'(ERR), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        REQ = 1'b0; RST = 1'b0;
        step();

        // Read, zero wait states
        REQ = 1'b1; WE = 1'b0; ADH_DATA = 8'h12; ADL_DATA = 8'h34; D_IN = 8'hA5; MEM_RDY = 1'b1;
        push(16'h1234, 1'b1, 1'b0, 8'hA5);
        step(); // cycle 1
        REQ = 1'b0;
        chk("rd_setup_busy", 32'(BUSY), 32'h1);
        chk("rd_setup_stb", 32'(STB), 32'h0);
        chk("rd_setup_a", 32'(A), 32'h1234);
        chk("rd_setup_rw", 32'(RW), 32'h1);
        chk("rd_setup_doe", 32'(D_OE), 32'h0);
        step(); // cycle 2
        chk("rd_strobe_stb", 32'(STB), 32'h1);
        chk("rd_strobe_doe", 32'(D_OE), 32'h0);
        chk("rd_strobe_ack", 32'(ACK), 32'h0);
        step(); // cycle 3
        chk("rd_done_ack", 32'(ACK), 32'h1);
        chk("rd_done_stb", 32'(STB), 32'h0);
        chk("rd_done_data", 32'(RD_DATA), 32'hA5);
        step(); // cycle 4
        chk("rd_idle_busy", 32'(BUSY), 32'h0);
        chk("rd_idle_ack", 32'(ACK), 32'h0);

        // Write, 3 wait states
        REQ = 1'b1; WE = 1'b1; ADH_DATA = 8'hFF; ADL_DATA = 8'hFE; DB_DATA = 8'h5A;
        D_IN = 8'h3C; MEM_RDY = 1'b0;
        push(16'hFFFE, 1'b0, 1'b0, 8'hA5);
        step(); // cycle 1
        REQ = 1'b0; DB_DATA = 8'h00; ADL_DATA = 8'h00;
        chk("wr_setup_doe", 32'(D_OE), 32'h1);
        chk("wr_setup_rw", 32'(RW), 32'h0);
        chk("wr_setup_dout", 32'(D_OUT), 32'h5A);
        chk("wr_setup_stb", 32'(STB), 32'h0);
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("wr_strobe_stb", 32'(STB), 32'h1);
            chk("wr_strobe_doe", 32'(D_OE), 32'h1);
            chk("wr_strobe_a", 32'(A), 32'hFFFE);
            chk("wr_strobe_dout", 32'(D_OUT), 32'h5A);
            if (c == 5) MEM_RDY = 1'b1;
        end
        step(); // cycle 6
        chk("wr_done_ack", 32'(ACK), 32'h1);
        chk("wr_done_doe", 32'(D_OE), 32'h0);
        chk("wr_done_rd_data", 32'(RD_DATA), 32'hA5);
        step();

        // REQ held through ACK: two reads back-to-back
        REQ = 1'b1; WE = 1'b0; ADH_DATA = 8'h80; ADL_DATA = 8'h00; D_IN = 8'h11; MEM_RDY = 1'b1;
        push(16'h8000, 1'b1, 1'b0, 8'h11);
        push(16'h0001, 1'b1, 1'b0, 8'h22);
        step(); // cycle 1
        ADH_DATA = 8'h00; ADL_DATA = 8'h01; WE = 1'b1; DB_DATA = 8'hEE;
        chk("b2b_setup_a", 32'(A), 32'h8000);
        step(); // cycle 2
        chk("b2b_strobe_a", 32'(A), 32'h8000);
        chk("b2b_strobe_rw", 32'(RW), 32'h1);
        chk("b2b_strobe_doe", 32'(D_OE), 32'h0);
        step(); // cycle 3
        WE = 1'b0; D_IN = 8'h22;
        chk("b2b_ack1", 32'(ACK), 32'h1);
        chk("b2b_rd1", 32'(RD_DATA), 32'h11);
        step(); // cycle 4
        chk("b2b_idle_busy", 32'(BUSY), 32'h0);
        step(); // cycle 5
        chk("b2b_setup2_a", 32'(A), 32'h0001);
        chk("b2b_setup2_ack", 32'(ACK), 32'h0);
        step(); // cycle 6
        chk("b2b_strobe2_ack", 32'(ACK), 32'h0);
        step(); // cycle 7
        REQ = 1'b0;
        chk("b2b_ack2", 32'(ACK), 32'h1);
        chk("b2b_rd2", 32'(RD_DATA), 32'h22);
        step(); // cycle 8
        chk("b2b_end_busy", 32'(BUSY), 32'h0);
        step();

        // Reset during STROBE of a write: no ACK
        REQ = 1'b1; WE = 1'b1; ADH_DATA = 8'h43; ADL_DATA = 8'h21; DB_DATA = 8'h99; MEM_RDY = 1'b0;
        step(); // cycle 1
        REQ = 1'b0;
        step(); // cycle 2
        chk("abort_strobe_stb", 32'(STB), 32'h1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("abort_stb", 32'(STB), 32'h0);
        chk("abort_doe", 32'(D_OE), 32'h0);
        chk("abort_rw", 32'(RW), 32'h1);
        chk("abort_ack", 32'(ACK), 32'h0);
        chk("abort_busy", 32'(BUSY), 32'h0);
        chk("abort_a", 32'(A), 32'h0000);
        chk("abort_rd_data", 32'(RD_DATA), 32'h00);
        step(); step();

        // Memory never ready
        REQ = 1'b1; WE = 1'b0; ADH_DATA = 8'h0B; ADL_DATA = 8'hAD; D_IN = 8'hFF; MEM_RDY = 1'b0;
`ifdef MEMBUS_TIMEOUT_EN
        push(16'h0BAD, 1'b1, 1'b1, 8'h00);
        step(); // cycle 1
        REQ = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            step();
            chk("to_wait_stb", 32'(STB), 32'h1);
            chk("to_wait_ack", 32'(ACK), 32'h0);
        end
        step(); // cycle 6
        chk("to_ack", 32'(ACK), 32'h1);
        chk("to_err", 32'(ERR), 32'h1);
        chk("to_rd_data", 32'(RD_DATA), 32'h00);
        step();
`else
        push(16'h0BAD, 1'b1, 1'b0, 8'hFF);
        step(); // cycle 1
        REQ = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 100; c++) begin
            if (BUSY === 1'b1 && ACK === 1'b0) busy_cycles++;
            step();
        end
        chk("stuck_busy_cycles", 32'(busy_cycles), 32'd100);
        chk("stuck_stb", 32'(STB), 32'h1);
        MEM_RDY = 1'b1;
        step();
        chk("stuck_release_ack", 32'(ACK), 32'h1);
        chk("stuck_release_err", 32'(ERR), 32'h0);
        step();
`endif
        busy_cycles = 0;
        step(); step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("ack_count", 32'(acks), 32'd5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
